// File: rtl/seq_detect_ctrl.sv
// Serial pattern detector with run control: y pulses one cycle after the matching bit is sampled.
// No backpressure: x is consumed on every x_valid cycle in RUN and ignored otherwise.
module seq_detect_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_load,
   input  logic [7:0]       cfg_pattern,
   input  logic [2:0]       cfg_len,
   input  logic             cfg_overlap,
   input  logic [3:0]       cfg_target,
   input  logic             start,
   input  logic             stop,
   input  logic             x,
   input  logic             x_valid,
   output logic             y,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       pat_q, pat_d;
   logic [2:0]       len_m1_q, len_m1_d;
   logic             ovl_q, ovl_d;
   logic [3:0]       tgt_q, tgt_d;
   logic [7:0]       sh_q, sh_d;
   logic [3:0]       fill_q, fill_d;
   logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
   logic             y_q, y_d;

   logic [7:0]       sh_shift;
   logic [7:0]       mask;
   logic [3:0]       len;
   logic [3:0]       fill_inc;
   logic [CNT_W-1:0] cnt_inc;
   logic             match;

   // Datapath view of the next sample; only acted on in RUN.
   always_comb begin
      sh_shift = {sh_q[6:0], x};
      len      = {1'b0, len_m1_q} + 4'd1;
      mask     = 8'hFF >> (3'd7 - len_m1_q);
      fill_inc = (fill_q < len) ? fill_q + 4'd1 : fill_q;
      match    = x_valid && (fill_inc >= len) && ((sh_shift & mask) == (pat_q & mask));
      cnt_inc  = (match_cnt_q == {CNT_W{1'b1}}) ? match_cnt_q : match_cnt_q + CNT_W'(1);
   end

   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      len_m1_d    = len_m1_q;
      ovl_d       = ovl_q;
      tgt_d       = tgt_q;
      sh_d        = sh_q;
      fill_d      = fill_q;
      match_cnt_d = match_cnt_q;
      y_d         = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (cfg_load) begin
               pat_d    = cfg_pattern;
               len_m1_d = cfg_len;
               ovl_d    = cfg_overlap;
               tgt_d    = cfg_target;
            end
            if (start) begin
               state_d     = RUN;
               sh_d        = 8'd0;
               fill_d      = 4'd0;
               match_cnt_d = '0;
            end
         end
         RUN: begin
            // stop wins over a match completing in the same cycle
            if (stop) begin
               state_d = IDLE;
            end else if (x_valid) begin
               sh_d   = sh_shift;
               fill_d = fill_inc;
               if (match) begin
                  y_d         = 1'b1;
                  match_cnt_d = cnt_inc;
                  if (!ovl_q) begin
                     fill_d = 4'd0;
                  end
                  if ((tgt_q != 4'd0) && (cnt_inc == CNT_W'(tgt_q))) begin
                     state_d = DONE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         pat_q       <= 8'b0000_0101;
         len_m1_q    <= 3'd2;
         ovl_q       <= 1'b1;
         tgt_q       <= 4'd0;
         sh_q        <= 8'd0;
         fill_q      <= 4'd0;
         match_cnt_q <= '0;
         y_q         <= 1'b0;
      end else begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         len_m1_q    <= len_m1_d;
         ovl_q       <= ovl_d;
         tgt_q       <= tgt_d;
         sh_q        <= sh_d;
         fill_q      <= fill_d;
         match_cnt_q <= match_cnt_d;
         y_q         <= y_d;
      end
   end

   assign y         = y_q;
   assign match_cnt = match_cnt_q;
   assign busy      = (state_q == RUN);
   assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Scoreboarded bench: stimulus pushes the expected post-edge outputs, a monitor pops and compares each cycle.
module tb_seq_detect_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cfg_load = 1'b0;
   logic [7:0] cfg_pattern = 8'd0;
   logic [2:0] cfg_len = 3'd0;
   logic       cfg_overlap = 1'b0;
   logic [3:0] cfg_target = 4'd0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       x = 1'b0;
   logic       x_valid = 1'b0;
   logic       y;
   logic [7:0] match_cnt;
   logic       busy;
   logic       done;

   seq_detect_ctrl #(.CNT_W(8)) dut (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .cfg_target(cfg_target),
      .start(start), .stop(stop), .x(x), .x_valid(x_valid),
      .y(y), .match_cnt(match_cnt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       y;
      logic [7:0] cnt;
      logic       busy;
      logic       done;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: history of valid bits since run start (or since the last non-overlapping match).
   int      m_state = 0;  // 0 idle, 1 run, 2 done
   bit      m_q[$];
   int      m_cnt = 0;
   bit [7:0] m_pat = 8'b101;
   int      m_len = 3;
   bit      m_ovl = 1'b1;
   int      m_tgt = 0;

   // Staged configuration driven onto cfg_* every cycle.
   bit [7:0] c_pat = 8'd0;
   bit [2:0] c_len = 3'd0;
   bit       c_ovl = 1'b0;
   bit [3:0] c_tgt = 4'd0;

   function automatic bit model_step(input bit rs, input bit cl, input bit st, input bit sp,
                                     input bit xv, input bit xx);
      bit hit = 1'b0;
      if (rs) begin
         m_state = 0; m_q.delete(); m_cnt = 0;
         m_pat = 8'b101; m_len = 3; m_ovl = 1'b1; m_tgt = 0;
         return 1'b0;
      end
      if (m_state != 1) begin
         if (cl) begin
            m_pat = c_pat; m_len = int'(c_len) + 1; m_ovl = c_ovl; m_tgt = int'(c_tgt);
         end
         if (st) begin
            m_state = 1; m_q.delete(); m_cnt = 0;
         end
      end else if (sp) begin
         m_state = 0;
      end else if (xv) begin
         m_q.push_back(xx);
         if (m_q.size() > 8) void'(m_q.pop_front());
         if (m_q.size() >= m_len) begin
            hit = 1'b1;
            for (int i = 0; i < m_len; i++)
               if (m_q[m_q.size() - 1 - i] != m_pat[i]) hit = 1'b0;
         end
         if (hit) begin
            if (m_cnt < 255) m_cnt++;
            if (!m_ovl) m_q.delete();
            if (m_tgt != 0 && m_cnt == m_tgt) m_state = 2;
         end
      end
      return hit;
   endfunction

   // One clock of stimulus, driven on the falling edge.
   task automatic tick(input bit xv = 0, input bit xx = 0, input bit st = 0,
                       input bit sp = 0, input bit cl = 0, input bit rs = 0);
      exp_t e;
      bit   hit;
      @(negedge clk);
      cfg_pattern = c_pat; cfg_len = c_len; cfg_overlap = c_ovl; cfg_target = c_tgt;
      cfg_load = cl; start = st; stop = sp; x = xx; x_valid = xv;
      rst = !rs;
      if (rs) begin
         #1;
         chk("async_rst_y", y, 0);
         chk("async_rst_cnt", match_cnt, 0);
         chk("async_rst_busy", busy, 0);
         chk("async_rst_done", done, 0);
      end
      hit    = model_step(rs, cl, st, sp, xv, xx);
      e.y    = hit;
      e.cnt  = 8'(m_cnt);
      e.busy = (m_state == 1);
      e.done = (m_state == 2);
      exp_q.push_back(e);
   endtask

   task automatic bits(input bit [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) tick(1, v[i]);
   endtask

   // Look at outputs right after the edge that consumed the last tick's inputs.
   task automatic peek(input string name, input int ey, input int ecnt, input int ebusy, input int edone);
      @(posedge clk);
      #3;
      chk({name, "_y"}, y, ey);
      chk({name, "_cnt"}, match_cnt, ecnt);
      chk({name, "_busy"}, busy, ebusy);
      chk({name, "_done"}, done, edone);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_y", y, e.y);
            chk("sb_cnt", match_cnt, e.cnt);
            chk("sb_busy", busy, e.busy);
            chk("sb_done", done, e.done);
         end
      end
   end

   initial begin : stim
      #3;
      chk("reset_y", y, 0);
      chk("reset_cnt", match_cnt, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      tick(.rs(1));
      tick();

      // Default overlapping 101 detector
      tick(.st(1));
      bits(8'b101, 3);
      peek("def_3rd", 1, 1, 1, 0);
      tick(1, 0);
      peek("def_4th", 0, 1, 1, 0);
      tick(1, 1);
      peek("def_5th", 1, 2, 1, 0);

      // Non-overlapping 101: needs a stop first so cfg_load is accepted
      tick(.sp(1));
      c_pat = 8'b101; c_len = 3'd2; c_ovl = 1'b0; c_tgt = 4'd0;
      tick(.cl(1));
      tick(.st(1));
      bits(8'b10101, 5);
      peek("novl", 0, 1, 1, 0);

      // Target of two, config captured in the start cycle
      tick(.sp(1));
      c_ovl = 1'b1; c_tgt = 4'd2;
      tick(.st(1), .cl(1));
      bits(8'b101101, 6);
      peek("tgt_done", 1, 2, 0, 1);
      bits(8'b101, 3);
      peek("tgt_hold", 0, 2, 0, 1);
      tick(.sp(1));
      peek("tgt_stop_ign", 0, 2, 0, 1);

      // Valid gaps, then stop on the completing bit
      c_tgt = 4'd0;
      tick(.st(1), .cl(1));
      tick(1, 1); tick(); tick(1, 0); tick(); tick();
      tick(1, 1);
      peek("gap_hit", 1, 1, 1, 0);
      tick(.sp(1));
      tick(.st(1));
      tick(1, 1); tick(1, 0);
      tick(1, 1, 0, 1);
      peek("stop_disc", 0, 0, 0, 0);

      // cfg_load during RUN must not take effect
      tick(.st(1));
      c_pat = 8'd0; c_len = 3'd0;
      tick(.cl(1));
      bits(8'b101, 3);
      peek("cfg_in_run", 1, 1, 1, 0);

      // len=1, pattern 1: every valid 1 matches
      tick(.sp(1));
      c_pat = 8'd1; c_len = 3'd0;
      tick(.st(1), .cl(1));
      tick(1, 1);
      peek("len1_a", 1, 1, 1, 0);
      tick(1, 0);
      peek("len1_b", 0, 1, 1, 0);
      tick(1, 1);
      peek("len1_c", 1, 2, 1, 0);

      // Reset mid-run, then counter saturation
      tick(.rs(1));
      tick();
      peek("post_rst", 0, 0, 0, 0);
      tick(.st(1), .cl(1));
      for (int i = 0; i < 300; i++) tick(1, 1);
      peek("sat", 1, 255, 1, 0);
      tick(.sp(1));

      // Randomized traffic against the model
      for (int i = 0; i < 4000; i++) begin
         bit cl, st, sp, xv, xx;
         cl = ($urandom_range(0, 7) == 0);
         if (cl) begin
            c_pat = 8'($urandom);
            c_len = 3'($urandom_range(0, 3));
            c_ovl = 1'($urandom);
            c_tgt = 4'($urandom_range(0, 4));
         end
         st = ($urandom_range(0, 5) == 0);
         sp = ($urandom_range(0, 63) == 0);
         xv = ($urandom_range(0, 3) != 0);
         xx = 1'($urandom);
         tick(xv, xx, st, sp, cl, ($urandom_range(0, 999) == 0));
      end
      tick();
      tick();
      @(posedge clk);
      #3;
      chk("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 8, setting the width of match_cnt.
REQ-002 SHALL have port clk, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low (rst=0 resets).
REQ-004 SHALL have port cfg_load, input, 1 bit: capture configuration inputs.
REQ-005 SHALL have port cfg_pattern, input, 8 bits: target pattern; bit 0 = most recent bit, bit len-1 = oldest.
REQ-006 SHALL have port cfg_len, input, 3 bits: pattern length minus 1 (len = 1..8).
REQ-007 SHALL have port cfg_overlap, input, 1 bit: 1 = overlapping detection, 0 = non-overlapping.
REQ-008 SHALL have port cfg_target, input, 4 bits: number of matches that ends a run; 0 = unlimited.
REQ-009 SHALL have port start, input, 1 bit: begin a detection run.
REQ-010 SHALL have port stop, input, 1 bit: abort a run.
REQ-011 SHALL have port x, input, 1 bit: serial data bit.
REQ-012 SHALL have port x_valid, input, 1 bit: x is sampled only when x_valid=1.
REQ-013 SHALL have port y, output, 1 bit: registered one-cycle match pulse.
REQ-014 SHALL have port match_cnt, output, CNT_W bits: matches counted in the current run.
REQ-015 SHALL have port busy, output, 1 bit: 1 while in RUN.
REQ-016 SHALL have port done, output, 1 bit: 1 while in DONE.

Function
REQ-017 SHALL implement FSM states IDLE, RUN and DONE.
REQ-018 SHALL hold config registers pat, len_m1, ovl and tgt, loaded on cfg_load only in IDLE or DONE; cfg_load in RUN is ignored.
REQ-019 SHALL, on cfg_load and start in the same IDLE/DONE cycle, capture the new configuration and use it for the run started in that cycle.
REQ-020 SHALL transition IDLE->RUN or DONE->RUN on start, clearing the shift register sh[7:0], fill counter and match_cnt; start in RUN is ignored.
REQ-021 SHALL, in RUN when x_valid=1, shift sh <= {sh[6:0],x} and increment fill, saturating at len; x_valid=0 changes nothing.
REQ-022 SHALL declare a match when the post-shift fill >= len and the post-shift sh[len-1:0] equals pat[len-1:0].
REQ-023 SHALL, on match, assert y for exactly the following cycle and increment match_cnt, saturating at 2^CNT_W-1.
REQ-024 SHALL, on match with ovl=1, leave fill unchanged; with ovl=0, clear fill to 0 so that matched bits are not reused.
REQ-025 SHALL, when tgt!=0 and a match brings match_cnt equal to tgt, transition RUN->DONE; y still pulses for that match.
REQ-026 SHALL, on stop in RUN, transition to IDLE; a match in the same cycle is discarded (no y, no count).
REQ-027 SHALL ignore x and x_valid in IDLE and DONE; match_cnt holds its value in IDLE and DONE.
REQ-028 SHALL keep done asserted until the next start, and SHALL ignore stop in IDLE and DONE.

Reset
REQ-029 SHALL, on rst=0, immediately force state=IDLE, y=0, match_cnt=0, busy=0, done=0, sh=0 and fill=0, including mid-run.
REQ-030 SHALL reset the configuration to pat=8'b00000101, len_m1=2, ovl=1, tgt=0, i.e. an overlapping "101" detector.

Verification
REQ-031 SHALL verify the default configuration: release reset, start, x_valid=1 with x=1,0,1,0,1 -> y pulses after the 3rd and 5th bits, match_cnt=2, busy=1, done=0.
REQ-032 SHALL verify non-overlap mode: cfg_load with pattern 101 and cfg_overlap=0, start, x=1,0,1,0,1 -> a single y after the 3rd bit, match_cnt=1.
REQ-033 SHALL verify target termination: cfg_target=2 (overlapping), x=1,0,1,1,0,1 -> y after the 3rd and 6th bits, done=1, busy=0, and further x=1,0,1 leaves match_cnt=2.
REQ-034 SHALL verify valid gaps and stop: x_valid=0 cycles interleaved in 1,0,1 -> y only after the 3rd valid bit; stop asserted on the completing bit -> no y, count unchanged, state IDLE.
REQ-035 SHALL verify configuration rules: cfg_load during RUN -> configuration unchanged; len=1 with pattern 1 -> y after every valid x=1; rst=0 mid-run -> all outputs 0 within the same cycle.
